// File: rtl/cpu_bus_interface.sv
// cpu_bus_interface
//   External-bus sequencer between the 6502 core and the TT pins. A latched CPU
//   address is serialised over a narrow pin bus, most significant beat first,
//   followed by a single read or write data phase. The data phase is stretched
//   by a fixed number of wait states and by pin_rdy. When HI_REUSE is set, the
//   upper beats are skipped if they are unchanged since the last transaction.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req, we, addr, wdata CPU request; sampled only while busy=0
//   busy, ack, rdata    CPU status: in progress, one-cycle completion, read data
//   pin_addr, pin_beat  current address beat and its index
//   pin_ale             address beat valid
//   pin_rw              1 = read, 0 = write
//   pin_oe, pin_dout    write data drive enable and write data
//   pin_din, pin_rdy    read data from the pins, external ready
module cpu_bus_interface #(
  parameter  int ADDR_W      = 16,
  parameter  int PIN_W       = 8,
  parameter  int DATA_W      = 8,
  parameter  int WAIT_STATES = 0,
  parameter  int HI_REUSE    = 1,
  localparam int BEATS       = (ADDR_W + PIN_W - 1) / PIN_W,
  localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [PIN_W-1:0]  pin_addr,
  output logic [BEAT_W-1:0] pin_beat,
  output logic              pin_ale,
  output logic              pin_rw,
  output logic              pin_oe,
  output logic [DATA_W-1:0] pin_dout,
  input  logic [DATA_W-1:0] pin_din,
  input  logic              pin_rdy
);

  localparam int PAD_W  = BEATS * PIN_W;
  localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_we;
  logic [PAD_W-1:0]    r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BEAT_W-1:0]   r_beat;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic [PAD_W-1:0]    r_hi_last;
  logic                r_hi_valid;

  logic [PAD_W-1:0]    w_addr_pad;
  logic                w_hi_match;
  logic                w_accept;
  logic                w_data_done;

  // Zero-extension leaves unused top-beat bits at 0 on the pins.
  assign w_addr_pad  = PAD_W'(addr);

  // Only the bits above beat 0 are compared; the full previous address is kept
  // so that the BEATS==1 case needs no zero-width vector.
  assign w_hi_match  = (HI_REUSE != 0) && r_hi_valid &&
                       ((w_addr_pad >> PIN_W) == (r_hi_last >> PIN_W));

  assign w_accept    = (r_state == S_IDLE) && req;
  assign w_data_done = (r_state == S_DATA) && (r_wait == '0) && pin_rdy;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req)           w_state_next = S_ADDR;
      S_ADDR:  if (r_beat == '0)  w_state_next = S_DATA;
      S_DATA:  if (w_data_done)   w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // Transaction datapath: latched request, beat and wait counters, history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_beat     <= '0;
      r_wait     <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_hi_last  <= '0;
      r_hi_valid <= 1'b0;
    end else begin
      r_ack <= w_data_done;

      if (w_accept) begin
        r_we    <= we;
        r_addr  <= w_addr_pad;
        r_wdata <= wdata;
        r_beat  <= w_hi_match ? '0 : BEAT_W'(BEATS - 1);
      end

      if (r_state == S_ADDR) begin
        if (r_beat != '0) begin
          r_beat <= r_beat - BEAT_W'(1);
        end else begin
          r_wait <= WAIT_W'(WAIT_STATES);
        end
      end

      // The wait counter runs regardless of pin_rdy; rdy only matters at 0.
      if ((r_state == S_DATA) && (r_wait != '0)) begin
        r_wait <= r_wait - WAIT_W'(1);
      end

      if (w_data_done) begin
        if (!r_we) begin
          r_rdata <= pin_din;
        end
        r_hi_last  <= r_addr;
        r_hi_valid <= 1'b1;
      end
    end
  end

  // Output decode from registered state and counters.
  always_comb begin
    busy     = (r_state != S_IDLE);
    ack      = r_ack;
    rdata    = r_rdata;
    pin_addr = '0;
    pin_beat = '0;
    pin_ale  = 1'b0;
    pin_rw   = 1'b1;
    pin_oe   = 1'b0;
    pin_dout = '0;
    case (r_state)
      S_ADDR: begin
        pin_ale  = 1'b1;
        pin_addr = PIN_W'(r_addr >> (int'(r_beat) * PIN_W));
        pin_beat = r_beat;
      end
      S_DATA: begin
        pin_rw   = ~r_we;
        pin_oe   = r_we;
        pin_dout = r_we ? r_wdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_interface.sv
// tb_cpu_bus_interface
//   Directed bench for cpu_bus_interface. Four instances share one stimulus:
//   A default build, B without upper-beat reuse, C with two wait states and
//   D with a 12-bit address over 4 pins. Each step checks only the instance
//   whose behaviour it targets; the others simply run along.
module tb_cpu_bus_interface;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  pin_din;
  logic        pin_rdy;

  logic       a_busy, a_ack, a_ale, a_rw, a_oe;
  logic [7:0] a_rdata, a_addr, a_dout;
  logic       a_beat;

  logic       b_busy, b_ack, b_ale, b_rw, b_oe;
  logic [7:0] b_rdata, b_addr, b_dout;
  logic       b_beat;

  logic       c_busy, c_ack, c_ale, c_rw, c_oe;
  logic [7:0] c_rdata, c_addr, c_dout;
  logic       c_beat;

  logic       d_busy, d_ack, d_ale, d_rw, d_oe;
  logic [7:0] d_rdata, d_dout;
  logic [3:0] d_addr;
  logic [1:0] d_beat;

  int unsigned n_vec;
  int unsigned n_err;

  cpu_bus_interface u_a (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(a_busy), .ack(a_ack), .rdata(a_rdata), .pin_addr(a_addr),
    .pin_beat(a_beat), .pin_ale(a_ale), .pin_rw(a_rw), .pin_oe(a_oe),
    .pin_dout(a_dout), .pin_din(pin_din), .pin_rdy(pin_rdy)
  );

  cpu_bus_interface #(.HI_REUSE(0)) u_b (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(b_busy), .ack(b_ack), .rdata(b_rdata), .pin_addr(b_addr),
    .pin_beat(b_beat), .pin_ale(b_ale), .pin_rw(b_rw), .pin_oe(b_oe),
    .pin_dout(b_dout), .pin_din(pin_din), .pin_rdy(pin_rdy)
  );

  cpu_bus_interface #(.WAIT_STATES(2)) u_c (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(c_busy), .ack(c_ack), .rdata(c_rdata), .pin_addr(c_addr),
    .pin_beat(c_beat), .pin_ale(c_ale), .pin_rw(c_rw), .pin_oe(c_oe),
    .pin_dout(c_dout), .pin_din(pin_din), .pin_rdy(pin_rdy)
  );

  cpu_bus_interface #(.ADDR_W(12), .PIN_W(4)) u_d (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr[11:0]), .wdata(wdata),
    .busy(d_busy), .ack(d_ack), .rdata(d_rdata), .pin_addr(d_addr),
    .pin_beat(d_beat), .pin_ale(d_ale), .pin_rw(d_rw), .pin_oe(d_oe),
    .pin_dout(d_dout), .pin_din(pin_din), .pin_rdy(pin_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    req     = 1'b0;
    we      = 1'b0;
    addr    = 16'h0000;
    wdata   = 8'h00;
    pin_din = 8'h5A;
    pin_rdy = 1'b1;

    // Reset state
    cyc();
    cyc();
    chk("rst_busy",  a_busy,  1'b0);
    chk("rst_ack",   a_ack,   1'b0);
    chk("rst_rdata", a_rdata, 8'h00);
    chk("rst_paddr", a_addr,  8'h00);
    chk("rst_beat",  a_beat,  1'b0);
    chk("rst_ale",   a_ale,   1'b0);
    chk("rst_rw",    a_rw,    1'b1);
    chk("rst_oe",    a_oe,    1'b0);
    chk("rst_dout",  a_dout,  8'h00);
    rst = 1'b0;
    cyc();

    // Full two-beat read of 0x12AB
    req = 1'b1; we = 1'b0; addr = 16'h12AB;
    cyc();
    req = 1'b0;
    chk("t1_c1_ale",   a_ale,  1'b1);
    chk("t1_c1_addr",  a_addr, 8'h12);
    chk("t1_c1_beat",  a_beat, 1'b1);
    chk("t1_c1_busy",  a_busy, 1'b1);
    chk("t1_b_c1addr", b_addr, 8'h12);
    cyc();
    chk("t1_c2_addr",  a_addr, 8'hAB);
    chk("t1_c2_beat",  a_beat, 1'b0);
    chk("t1_c2_ale",   a_ale,  1'b1);
    cyc();
    chk("t1_c3_ale",   a_ale,  1'b0);
    chk("t1_c3_rw",    a_rw,   1'b1);
    chk("t1_c3_oe",    a_oe,   1'b0);
    chk("t1_c3_paddr", a_addr, 8'h00);
    chk("t1_c3_ack",   a_ack,  1'b0);
    chk("t1_c3_busy",  a_busy, 1'b1);
    cyc();
    chk("t1_c4_ack",   a_ack,   1'b1);
    chk("t1_c4_busy",  a_busy,  1'b0);
    chk("t1_c4_rdata", a_rdata, 8'h5A);
    chk("t1_b_c4ack",  b_ack,   1'b1);

    // Back-to-back read of 0x12AC in the ack cycle: A reuses the upper beat
    req = 1'b1; addr = 16'h12AC; pin_din = 8'h77;
    cyc();
    req = 1'b0;
    chk("t2_c1_ale",   a_ale,  1'b1);
    chk("t2_c1_addr",  a_addr, 8'hAC);
    chk("t2_c1_beat",  a_beat, 1'b0);
    chk("t2_c1_ack",   a_ack,  1'b0);
    chk("t2_b_c1addr", b_addr, 8'h12);
    chk("t2_b_c1beat", b_beat, 1'b1);
    cyc();
    chk("t2_c2_ale",   a_ale,  1'b0);
    chk("t2_c2_busy",  a_busy, 1'b1);
    chk("t2_b_c2addr", b_addr, 8'hAC);
    chk("t2_b_c2beat", b_beat, 1'b0);
    cyc();
    chk("t2_c3_ack",   a_ack,   1'b1);
    chk("t2_c3_rdata", a_rdata, 8'h77);
    chk("t2_b_c3ack",  b_ack,   1'b0);
    chk("t2_b_c3busy", b_busy,  1'b1);
    cyc();
    chk("t2_c4_ack",   a_ack,   1'b0);
    chk("t2_b_c4ack",  b_ack,   1'b1);
    chk("t2_b_rdata",  b_rdata, 8'h77);
    idle(10);

    // Request re-driven with a different address while busy is ignored
    pin_din = 8'h3C;
    req = 1'b1; addr = 16'h5678;
    cyc();
    addr = 16'h9999;
    chk("t4_c1_addr", a_addr, 8'h56);
    chk("t4_c1_beat", a_beat, 1'b1);
    cyc();
    chk("t4_c2_addr", a_addr, 8'h78);
    chk("t4_c2_beat", a_beat, 1'b0);
    cyc();
    chk("t4_c3_ale",  a_ale,  1'b0);
    chk("t4_c3_busy", a_busy, 1'b1);
    req = 1'b0;
    cyc();
    chk("t4_c4_ack",   a_ack,   1'b1);
    chk("t4_c4_rdata", a_rdata, 8'h3C);
    cyc();
    chk("t4_c5_ack",  a_ack,  1'b0);
    chk("t4_c5_busy", a_busy, 1'b0);
    idle(10);

    // Reset in the data phase of a reused-beat read, then history is gone
    pin_din = 8'h11;
    req = 1'b1; addr = 16'h5611;
    cyc();
    req = 1'b0;
    chk("t5_c1_beat", a_beat, 1'b0);
    chk("t5_c1_addr", a_addr, 8'h11);
    cyc();
    chk("t5_c2_busy", a_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy",  a_busy, 1'b0);
    chk("t5_rst_ack",   a_ack,  1'b0);
    chk("t5_rst_rw",    a_rw,   1'b1);
    chk("t5_rst_ale",   a_ale,  1'b0);
    chk("t5_rst_rdata", a_rdata, 8'h00);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t5_post_ack",  a_ack,  1'b0);
    chk("t5_post_busy", a_busy, 1'b0);
    req = 1'b1; addr = 16'h5622;
    cyc();
    req = 1'b0;
    chk("t5_full_addr", a_addr, 8'h56);
    chk("t5_full_beat", a_beat, 1'b1);
    idle(10);

    // Write with two wait states and pin_rdy low for two further cycles
    req = 1'b1; we = 1'b1; addr = 16'h34CD; wdata = 8'hEE;
    cyc();
    req = 1'b0; we = 1'b0;
    chk("t3_c1_addr", c_addr, 8'h34);
    chk("t3_c1_beat", c_beat, 1'b1);
    cyc();
    chk("t3_c2_addr", c_addr, 8'hCD);
    cyc();
    pin_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_data_oe",   c_oe,   1'b1);
      chk("t3_data_rw",   c_rw,   1'b0);
      chk("t3_data_dout", c_dout, 8'hEE);
      chk("t3_data_ack",  c_ack,  1'b0);
      if (i == 4) pin_rdy = 1'b1;
      cyc();
    end
    chk("t3_ack",  c_ack,  1'b1);
    chk("t3_oe",   c_oe,   1'b0);
    chk("t3_rw",   c_rw,   1'b1);
    chk("t3_dout", c_dout, 8'h00);
    chk("t3_busy", c_busy, 1'b0);
    idle(15);

    // Three-beat read on the 12-bit / 4-pin build
    pin_din = 8'h99;
    req = 1'b1; we = 1'b0; addr = 16'h0ABC;
    cyc();
    req = 1'b0;
    chk("t6_c1_addr", d_addr, 4'hA);
    chk("t6_c1_beat", d_beat, 2'd2);
    chk("t6_c1_ale",  d_ale,  1'b1);
    cyc();
    chk("t6_c2_addr", d_addr, 4'hB);
    chk("t6_c2_beat", d_beat, 2'd1);
    cyc();
    chk("t6_c3_addr", d_addr, 4'hC);
    chk("t6_c3_beat", d_beat, 2'd0);
    cyc();
    chk("t6_c4_ale",   d_ale,  1'b0);
    chk("t6_c4_paddr", d_addr, 4'h0);
    chk("t6_c4_rw",    d_rw,   1'b1);
    chk("t6_c4_busy",  d_busy, 1'b1);
    cyc();
    chk("t6_c5_ack",   d_ack,   1'b1);
    chk("t6_c5_rdata", d_rdata, 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
